// File: rtl/crc_pkg.sv
// Shared CRC-32 definitions for the serial generator and checker:
// polynomial, init/residue constants, the MSB-first LFSR step and the checker states.
package crc_pkg;

  localparam int               CRC_W       = 32;
  localparam logic [CRC_W-1:0] CRC_POLY    = 32'h04C1_1DB7;
  localparam logic [CRC_W-1:0] CRC_INIT    = {CRC_W{1'b1}};
  localparam logic [CRC_W-1:0] CRC_RESIDUE = {CRC_W{1'b0}};

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RX   = 1'b1
  } chk_state_e;

  // One Galois LFSR step, MSB first.
  function automatic logic [CRC_W-1:0] crc_step(
    input logic [CRC_W-1:0] crc,
    input logic             din,
    input logic [CRC_W-1:0] poly = CRC_POLY
  );
    logic fb;
    fb = crc[CRC_W-1] ^ din;
    return {crc[CRC_W-2:0], 1'b0} ^ (fb ? poly : {CRC_W{1'b0}});
  endfunction

endpackage

// File: rtl/crc32_chk_sat_cnt.sv
// Saturating up-counter with a synchronous clear that takes priority over increment.
module sat_cnt #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] q
);

  localparam logic [CW-1:0] Q_MAX = {CW{1'b1}};

  logic [CW-1:0] q_r;

  // Count up on inc, hold at all-ones, clear on rst or clr.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q_r <= {CW{1'b0}};
    end else if (inc && (q_r != Q_MAX)) begin
      q_r <= q_r + CW'(1);
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/crc32_chk.sv
// Bit-serial CRC-32 frame checker: runs the LFSR over payload+CRC, compares the
// final register with the residue, and keeps saturating good/bad frame counters.
module crc32_chk
  import crc_pkg::*;
#(
  parameter int               W        = CRC_W,
  parameter logic [W-1:0]     POLY     = CRC_POLY,
  parameter logic [W-1:0]     INIT     = CRC_INIT,
  parameter logic [W-1:0]     RESIDUE  = CRC_RESIDUE,
  parameter int               MIN_BITS = W + 1,
  parameter int               MAX_BITS = 16384,
  parameter int               CW       = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          vld,
  input  logic          sof,
  input  logic          eof,
  input  logic          din,
  output logic          done,
  output logic          ok,
  output logic          err_crc,
  output logic          err_len,
  output logic          abort,
  output logic [W-1:0]  crc,
  output logic [CW-1:0] ok_cnt,
  output logic [CW-1:0] bad_cnt
);

  // Bit counter stops one past MAX_BITS so any over-length frame stays detectable.
  localparam int            BW      = $clog2(MAX_BITS + 2);
  localparam logic [BW-1:0] CNT_SAT = BW'(MAX_BITS + 1);
  localparam logic [BW-1:0] CNT_MIN = BW'(MIN_BITS);
  localparam logic [BW-1:0] CNT_MAX = BW'(MAX_BITS);

  chk_state_e    state_r;
  logic [W-1:0]  crc_r;
  logic [BW-1:0] cnt_r;
  logic          done_r, ok_r, err_crc_r, err_len_r, abort_r;

  logic [W-1:0]  crc_nx_s;
  logic [BW-1:0] cnt_nx_s;
  logic          take_s, err_crc_s, err_len_s;
  logic          inc_ok_s, inc_bad_s;

  // Next LFSR/count values for the current beat; a sof restarts from INIT.
  always_comb begin
    crc_nx_s = crc_step(sof ? INIT : crc_r, din, POLY);
    if (sof) begin
      cnt_nx_s = BW'(1);
    end else if (cnt_r == CNT_SAT) begin
      cnt_nx_s = cnt_r;
    end else begin
      cnt_nx_s = cnt_r + BW'(1);
    end
    take_s    = vld && (sof || (state_r == RX));
    err_crc_s = (crc_nx_s != RESIDUE);
    err_len_s = (cnt_nx_s < CNT_MIN) || (cnt_nx_s > CNT_MAX);
  end

  // Frame FSM: accumulates bits in RX and issues the verdict the cycle after eof.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      crc_r     <= INIT;
      cnt_r     <= {BW{1'b0}};
      done_r    <= 1'b0;
      ok_r      <= 1'b0;
      err_crc_r <= 1'b0;
      err_len_r <= 1'b0;
      abort_r   <= 1'b0;
    end else begin
      done_r  <= 1'b0;
      abort_r <= 1'b0;
      if (take_s) begin
        abort_r <= sof && (state_r == RX);
        if (eof) begin
          state_r   <= IDLE;
          crc_r     <= INIT;
          cnt_r     <= {BW{1'b0}};
          done_r    <= 1'b1;
          ok_r      <= !err_crc_s && !err_len_s;
          err_crc_r <= err_crc_s;
          err_len_r <= err_len_s;
        end else begin
          state_r <= RX;
          crc_r   <= crc_nx_s;
          cnt_r   <= cnt_nx_s;
        end
      end else begin
        state_r <= state_r;
        crc_r   <= crc_r;
        cnt_r   <= cnt_r;
      end
    end
  end

  // Counters bump off the registered verdict, so a clr during the done cycle wins.
  assign inc_ok_s  = done_r && ok_r;
  assign inc_bad_s = (done_r && !ok_r) || abort_r;

  sat_cnt #(.CW(CW)) u_ok_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (inc_ok_s),
    .q   (ok_cnt)
  );

  sat_cnt #(.CW(CW)) u_bad_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (inc_bad_s),
    .q   (bad_cnt)
  );

  assign done    = done_r;
  assign ok      = ok_r;
  assign err_crc = err_crc_r;
  assign err_len = err_len_r;
  assign abort   = abort_r;
  assign crc     = crc_r;

endmodule

// File: tb/tb_crc32_chk.sv
// Randomised bench for crc32_chk: frames are judged by recomputing the payload CRC
// and comparing it with the transmitted trailer; a second instance checks CW=2 saturation.
module tb_crc32_chk;

  typedef bit bq_t[$];

  localparam logic [31:0] POLY = 32'h04C1_1DB7;
  localparam logic [31:0] INIT = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1, clr = 1'b0, vld = 1'b0, sof = 1'b0, eof = 1'b0, din = 1'b0;
  logic        done, ok, err_crc, err_len, abort;
  logic [31:0] crc;
  logic [15:0] ok_cnt, bad_cnt;
  logic        done2, ok2, err_crc2, err_len2, abort2;
  logic [31:0] crc2;
  logic [1:0]  ok_cnt2, bad_cnt2;

  int total = 0;
  int bad   = 0;

  bq_t fr_q;
  bit  in_frame = 1'b0;
  int  exp_ok = 0, exp_bad = 0, exp_ok2 = 0, exp_bad2 = 0;

  always #5 clk = ~clk;

  crc32_chk dut (
    .clk(clk), .rst(rst), .clr(clr), .vld(vld), .sof(sof), .eof(eof), .din(din),
    .done(done), .ok(ok), .err_crc(err_crc), .err_len(err_len), .abort(abort),
    .crc(crc), .ok_cnt(ok_cnt), .bad_cnt(bad_cnt)
  );

  crc32_chk #(.CW(2)) dut2 (
    .clk(clk), .rst(rst), .clr(clr), .vld(vld), .sof(sof), .eof(eof), .din(din),
    .done(done2), .ok(ok2), .err_crc(err_crc2), .err_len(err_len2), .abort(abort2),
    .crc(crc2), .ok_cnt(ok_cnt2), .bad_cnt(bad_cnt2)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Textbook MSB-first CRC-32/MPEG-2 of a payload (no final XOR).
  function automatic logic [31:0] crc_of(input bq_t p);
    logic [31:0] r;
    r = INIT;
    foreach (p[i]) begin
      if (r[31] ^ p[i]) r = {r[30:0], 1'b0} ^ POLY;
      else              r = {r[30:0], 1'b0};
    end
    return r;
  endfunction

  function automatic bq_t with_crc(input bq_t p);
    bq_t q;
    logic [31:0] c;
    q = p;
    c = crc_of(p);
    for (int i = 31; i >= 0; i--) q.push_back(c[i]);
    return q;
  endfunction

  function automatic bq_t rand_bits(input int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(1'($urandom));
    return q;
  endfunction

  function automatic int sat_add(input int v, input int lim);
    return (v >= lim) ? lim : v + 1;
  endfunction

  task automatic count_bad();
    exp_bad  = sat_add(exp_bad, 65535);
    exp_bad2 = sat_add(exp_bad2, 3);
  endtask

  // One clock beat: model the beat, drive it, then compare outputs #1 after the edge.
  task automatic beat(input logic v, input logic s, input logic e, input logic d, input logic c);
    bit x_done = 1'b0, x_abort = 1'b0, x_ok = 1'b0, x_len = 1'b0, x_crc = 1'b0, crc_known = 1'b0;
    int n;
    bq_t pay;
    logic [31:0] trail;
    vld = v; sof = s; eof = e; din = d; clr = c;
    if (v) begin
      if (s) begin
        if (in_frame) begin
          x_abort = 1'b1;
          count_bad();
        end
        fr_q.delete();
        fr_q.push_back(d);
        in_frame = 1'b1;
      end else if (in_frame) begin
        fr_q.push_back(d);
      end
      if (e && in_frame) begin
        n      = fr_q.size();
        x_done = 1'b1;
        x_len  = (n < 33) || (n > 16384);
        if (n >= 33) begin
          pay = fr_q[0:n-33];
          for (int i = 0; i < 32; i++) trail[31-i] = fr_q[n-32+i];
          x_crc     = (crc_of(pay) != trail);
          crc_known = 1'b1;
        end
        x_ok = !x_len && !x_crc && crc_known;
        if (x_ok) begin
          exp_ok  = sat_add(exp_ok, 65535);
          exp_ok2 = sat_add(exp_ok2, 3);
        end else begin
          count_bad();
        end
        in_frame = 1'b0;
      end
    end
    if (c) begin
      exp_ok = 0; exp_bad = 0; exp_ok2 = 0; exp_bad2 = 0;
    end
    @(posedge clk);
    #1;
    check_eq("done", done, x_done);
    check_eq("abort", abort, x_abort);
    if (x_done) begin
      check_eq("ok", ok, x_ok);
      check_eq("err_len", err_len, x_len);
      if (crc_known) check_eq("err_crc", err_crc, x_crc);
      check_eq("crc_reinit", crc, INIT);
      check_eq("ok_small", ok2, x_ok);
    end
  endtask

  task automatic idle(input int n, input logic c);
    for (int i = 0; i < n; i++) beat(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), c);
  endtask

  task automatic send_frame(input bq_t q, input bit gaps);
    for (int i = 0; i < q.size(); i++) begin
      if (gaps) while ($urandom_range(0, 2) == 0) idle(1, 1'b0);
      beat(1'b1, i == 0, i == q.size() - 1, q[i], 1'b0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; vld = 1'b0; clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    in_frame = 1'b0;
    exp_ok = 0; exp_bad = 0; exp_ok2 = 0; exp_bad2 = 0;
  endtask

  task automatic check_cnts(input string tag);
    idle(2, 1'b0);
    check_eq({tag, "_ok_cnt"}, ok_cnt, exp_ok);
    check_eq({tag, "_bad_cnt"}, bad_cnt, exp_bad);
    check_eq({tag, "_ok_cnt2"}, ok_cnt2, exp_ok2);
    check_eq({tag, "_bad_cnt2"}, bad_cnt2, exp_bad2);
  endtask

  initial begin
    bq_t f1, f2, p;
    logic [71:0] msg;
    logic [31:0] ref_crc;

    msg     = "123456789";
    ref_crc = 32'h0376_E6E7;
    for (int i = 71; i >= 0; i--) f1.push_back(msg[i]);
    for (int i = 31; i >= 0; i--) f1.push_back(ref_crc[i]);

    do_reset();
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_ok", ok, 1'b0);
    check_eq("rst_err_crc", err_crc, 1'b0);
    check_eq("rst_err_len", err_len, 1'b0);
    check_eq("rst_abort", abort, 1'b0);
    check_eq("rst_crc", crc, INIT);
    check_eq("rst_ok_cnt", ok_cnt, 16'd0);
    check_eq("rst_bad_cnt", bad_cnt, 16'd0);

    // Known-answer frame, plus a stray eof and garbage in IDLE that must be ignored.
    beat(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    send_frame(f1, 1'b0);
    check_eq("kat_ok", ok, 1'b1);
    check_cnts("t1");

    do_reset();
    f2 = f1;
    f2[5] = ~f2[5];
    send_frame(f2, 1'b0);
    check_cnts("t2");

    send_frame(rand_bits(20), 1'b0);
    send_frame(rand_bits(1), 1'b0);
    send_frame(with_crc(rand_bits(0)), 1'b0);
    send_frame(with_crc(rand_bits(1)), 1'b0);
    check_cnts("t3");

    do_reset();
    send_frame(rand_bits(40), 1'b0);
    send_frame(f1, 1'b0);
    check_cnts("t4");

    do_reset();
    send_frame(f1, 1'b1);
    for (int k = 0; k < 3; k++) send_frame(f1, 1'b0);
    check_cnts("t5");

    do_reset();
    for (int k = 0; k < 5; k++) send_frame(rand_bits(10 + k), 1'b0);
    check_cnts("t6_sat");
    send_frame(rand_bits(12), 1'b0);
    idle(1, 1'b1);
    check_cnts("t6_clr");

    for (int k = 0; k < 50; k++) beat(1'b1, k == 0, 1'b0, 1'($urandom), 1'b0);
    do_reset();
    idle(3, 1'b0);
    check_cnts("t6_rst");

    for (int k = 0; k < 20; k++) begin
      p = with_crc(rand_bits($urandom_range(1, 200)));
      if ($urandom_range(0, 2) == 0) begin
        int j = $urandom_range(0, p.size() - 1);
        p[j] = ~p[j];
      end
      send_frame(p, k[0]);
    end
    check_cnts("rand");

    send_frame(with_crc(rand_bits(16352)), 1'b0);
    send_frame(with_crc(rand_bits(16353)), 1'b0);
    check_cnts("maxlen");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
